// File: rtl/fsm3_word_scanner.sv
`default_nettype none
// ============================================================================
// Module      : fsm3_word_scanner
// Description : Word-level sequencer around a 4-state serial "101" detector
//               (states A/B/C/D). A WIDTH-bit word is accepted on an
//               in_valid/in_ready handshake and shifted LSB-first through the
//               detector at one bit per clock. Detector hits are counted, and
//               the hit count plus final detector state are returned on an
//               out_valid/out_ready handshake.
//
// Parameters  : WIDTH       data bits per word (>= 2)
//               KEEP_STATE  0: detector restarts at A for every word
//                           1: detector state carries over between words
//               HIT_W       width of the hit count
//
// Ports       : clk             clock, rising edge
//               areset          asynchronous active-high reset
//               in_valid        producer presents a word on in_data
//               in_ready        word can be accepted (IDLE only)
//               in_data         word to scan, bit 0 processed first
//               out_valid       result available (REPORT only)
//               out_ready       consumer accepts the result
//               out_hits        number of detector hits in the word
//               out_last_state  detector state after the last bit (A=0..D=3)
//               busy            high while shifting or reporting
//
// Revision    : 1.0  initial release
// ============================================================================
module fsm3_word_scanner #(
    parameter int WIDTH      = 16,
    parameter int KEEP_STATE = 0,
    parameter int HIT_W      = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [HIT_W-1:0] out_hits,
    output logic [1:0]       out_last_state,
    output logic             busy
);

    // Bit index only needs to reach WIDTH-1.
    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_REPORT = 2'd2
    } ctrl_state_t;

    // Encoding matches the out_last_state reporting (A=0 .. D=3).
    typedef enum logic [1:0] {
        DET_A = 2'd0,
        DET_B = 2'd1,
        DET_C = 2'd2,
        DET_D = 2'd3
    } det_state_t;

    ctrl_state_t      r_state;
    det_state_t       r_det;
    logic [WIDTH-1:0] r_shift;
    logic [IDX_W-1:0] r_idx;
    logic [HIT_W-1:0] r_hits;
    logic             r_out_valid;
    logic [HIT_W-1:0] r_out_hits;
    logic [1:0]       r_out_state;

    det_state_t       w_det_next;
    logic             w_bit;
    logic             w_hit;
    logic [HIT_W-1:0] w_hits_next;

    // ------------------------------------------------------------------
    // Detector next-state for the bit currently at the bottom of the
    // shift register. Only meaningful (and only used) in SHIFT.
    // ------------------------------------------------------------------
    always_comb begin
        w_bit      = r_shift[0];
        w_det_next = DET_A;
        case (r_det)
            DET_A:   w_det_next = w_bit ? DET_B : DET_A;
            DET_B:   w_det_next = w_bit ? DET_B : DET_C;
            DET_C:   w_det_next = w_bit ? DET_D : DET_A;
            DET_D:   w_det_next = w_bit ? DET_B : DET_C;
            default: w_det_next = DET_A;
        endcase
        // A hit is any bit that lands the detector in D; since D exits
        // to B/C, overlapping patterns are counted naturally.
        w_hit       = (w_det_next == DET_D);
        w_hits_next = r_hits + {{(HIT_W-1){1'b0}}, w_hit};
    end

    // ------------------------------------------------------------------
    // Control FSM, datapath and registered result outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_state     <= ST_IDLE;
            r_det       <= DET_A;
            r_shift     <= '0;
            r_idx       <= '0;
            r_hits      <= '0;
            r_out_valid <= 1'b0;
            r_out_hits  <= '0;
            r_out_state <= 2'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_shift <= in_data;
                        r_idx   <= '0;
                        r_hits  <= '0;
                        // With carry-over enabled the detector keeps
                        // whatever state the previous word left it in.
                        if (KEEP_STATE == 0) begin
                            r_det <= DET_A;
                        end
                        r_state <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    r_shift <= r_shift >> 1;
                    r_det   <= w_det_next;
                    r_hits  <= w_hits_next;
                    r_idx   <= r_idx + IDX_W'(1);
                    if (r_idx == c_last_idx) begin
                        // Capture the result including the final bit's
                        // contribution, so it is stable for all of REPORT.
                        r_out_hits  <= w_hits_next;
                        r_out_state <= w_det_next;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_REPORT;
                    end
                end

                ST_REPORT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end

                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    // Handshake status depends on the control state alone, so there is
    // no combinational path from in_valid/out_ready to any output.
    assign in_ready       = (r_state == ST_IDLE);
    assign busy           = (r_state != ST_IDLE);
    assign out_valid      = r_out_valid;
    assign out_hits       = r_out_hits;
    assign out_last_state = r_out_state;

endmodule
`default_nettype wire

// File: doc/fsm3_word_scanner.md
# fsm3_word_scanner

Word-level controller that sequences the 4-state serial "101" detector (states A/B/C/D) over parallel input words. Accepts a WIDTH-bit word on a valid/ready handshake, shifts it LSB-first through the detector at one bit per cycle, counts detector hits, and returns the hit count and final detector state on a second valid/ready handshake. It sits between a word-oriented producer and consumer and lets both use the bit-serial detector without managing bit timing.

## Interface
- WIDTH, 16, data bits per word; must be at least 2.
- KEEP_STATE, 0, detector handling between words:
  - 0: detector forced to A at each word accept.
  - 1: detector state carries over from the previous word.
- HIT_W, ceil(log2(WIDTH+1)), width of the hit count.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- areset  in  1  asynchronous, active-high reset.
- in_valid  in  1  producer has a word on in_data.
- in_ready  out  1  block can accept a word; high only in IDLE.
- in_data  in  WIDTH  word to scan; bit 0 is processed first.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_hits  out  HIT_W  number of detector hits in the word.
- out_last_state  out  2  detector state after the last bit (A=0, B=1, C=2, D=3).
- busy  out  1  high in SHIFT or REPORT.

## Operation
- Detector transitions, one per shifted bit b:
  - A: b ? B : A
  - B: b ? B : C
  - C: b ? D : A
  - D: b ? B : C
- Hit: a shifted bit whose next detector state is D.
- Hits overlap. For example, the stream 1,0,1,0,1 gives 2 hits.
- Control FSM has three states: IDLE, SHIFT, REPORT.
- IDLE:
  - in_ready=1.
  - On the edge where in_valid&&in_ready: capture in_data into the shift register.
  - Bit index is cleared to 0 and the hit counter is cleared to 0.
  - Detector is forced to A if KEEP_STATE=0; otherwise it is left unchanged.
  - Next state: SHIFT.
- SHIFT:
  - Each cycle, process bit[index]: update the detector and increment the hit counter on a hit.
  - Increment the index.
  - After the bit with index WIDTH-1 is processed, go to REPORT.
  - in_valid is ignored.
- REPORT:
  - out_valid=1.
  - out_hits and out_last_state are registered and stay stable until the handshake.
  - On the edge where out_valid&&out_ready, go to IDLE.
  - out_valid drops in the next cycle.
- Hit counter: HIT_W bits, no saturation required. WIDTH hits cannot occur because the first hit needs at least one 0 before it.
- Outputs outside REPORT:
  - out_hits and out_last_state hold their last reported values.
  - Only out_valid qualifies them.
- areset, asynchronous and at any time, including mid-SHIFT or mid-REPORT:
  - Control FSM goes to IDLE; detector goes to A.
  - Index, hit counter, out_hits and out_last_state go to 0.
  - out_valid=0, busy=0, in_ready=1.
  - Any partial word is discarded with no result produced.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, out_hits=0, out_last_state=0.
- Word accepted on edge E0. SHIFT occupies the cycles after edges E0 through E0+WIDTH-1.
- out_valid rises after edge E0+WIDTH; latency is WIDTH cycles from accept to out_valid.
- With out_ready held high, REPORT lasts 1 cycle. The next accept can happen 1 cycle after REPORT.
- Minimum period: WIDTH+2 cycles per word.
- in_ready and busy are decoded combinationally from the FSM state only. No combinational path runs from in_valid or out_ready to any output.
- out_ready high outside REPORT has no effect.

## Test plan
- **Single match:** reset, KEEP_STATE=0, in_data=16'h0005 -> out_hits=1, out_last_state=0 (A), out_valid 16 cycles after accept.
- **Overlapping matches:** in_data=16'h5555 -> out_hits=7, out_last_state=2 (C).
- **All ones:** in_data=16'hFFFF -> out_hits=0, out_last_state=1 (B).
- **State carry-over:** send 16'h8000 then 16'h0002 back to back.
  - KEEP_STATE=1: first result hits=0, state B; second result hits=1, state A.
  - KEEP_STATE=0: second result hits=0, state A.
- **Backpressure:** out_ready held low for 5 cycles in REPORT while in_valid=1 with 16'hFFFF.
  - out_valid, out_hits and out_last_state stay stable; in_ready=0; the new word is not taken.
  - After out_ready pulses: out_valid drops next cycle, then the word is accepted in IDLE.
- **Reset mid-SHIFT:** assert areset after 8 bits of 16'h5555.
  - All outputs return to reset values immediately, with no out_valid.
  - After release, 16'h0005 yields hits=1.
